fifo_wr_level: RTL
==================

// Module: fifo_wr_level
// PURPOSE
//  Synchronous single-clock FIFO with occupancy level, almost-full/almost-empty flags and synchronous flush.
//  Supports any DEPTH >= 2, not only powers of two.
//  Sits between bus-side producers and peripheral consumers (UART/timer/DMA queues) that need watermark interrupts.
//  Port naming: w_valid = "space available" (output), w_ready = push strobe; r_valid = "data available", r_ready = pop strobe.
// PARAMETERS
//  WIDTH      8         data width in bits
//  DEPTH      6         number of entries; any value >= 2
//  SKID       0         1: w_valid also asserted when r_ready=1 (push into full FIFO during same-cycle pop)
//  AF_THRESH  DEPTH-1   almost_full asserted when level >= AF_THRESH
//  AE_THRESH  1         almost_empty asserted when level <= AE_THRESH
//  LVL_W      $clog2(DEPTH+1)  derived; width of level, do not override
// PORTS
//  clk           in   1      clock; all state updates on rising edge
//  rst_n         in   1      reset, synchronous, active-low
//  flush         in   1      synchronous clear of pointers/level; memory contents not cleared
//  w_valid       out  1      FIFO can accept a write this cycle
//  w_ready       in   1      write request; push = w_valid & w_ready
//  w_data        in   WIDTH  write data
//  r_valid       out  1      FIFO holds at least one entry
//  r_ready       in   1      read request; pop = r_valid & r_ready
//  r_data        out  WIDTH  head entry, combinational from memory
//  level         out  LVL_W  current number of entries, 0..DEPTH
//  almost_full   out  1      level >= AF_THRESH
//  almost_empty  out  1      level <= AE_THRESH
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low (rst_n sampled on clk rising edge).
//  - Reset / flush: w_ptr=r_ptr=0, phases=0, level=0 -> w_valid=1, r_valid=0, almost_full=(0>=AF_THRESH), almost_empty=1.
//  - Priority: rst_n low > flush > push/pop; push/pop in a flush cycle are discarded.
//  - Reset mid-operation: all queued data lost at the next edge; no partial state kept.
//  - Push: mem[w_ptr] <= w_data; w_ptr advances. Pop: r_ptr advances. Ignored when the qualifying valid is 0.
//  - Pointers count 0..DEPTH-1 and wrap to 0, toggling a phase bit; full = ptrs equal & phases differ; empty = ptrs & phases equal.
//  - level register: +1 push only, -1 pop only, unchanged on both/neither; always equals entry count, never exceeds DEPTH.
//  - Latency: pushed word visible on r_data with r_valid=1 the cycle after push; no same-cycle bypass when empty.
//  - Empty: r_valid=0, r_data undefined (don't-care); r_ready ignored.
//  - Full, SKID=0: w_valid=0, w_ready ignored regardless of r_ready.
//  - Full, SKID=1: w_valid = r_ready; push+pop in same cycle, level stays DEPTH, new word written to freed slot.
//  - Flags, w_valid, r_valid derived combinationally from registered state (plus r_ready when SKID=1); no glitch-free guarantee.
//  - Parameter checks: DEPTH>=2, AE_THRESH < AF_THRESH <= DEPTH; violation -> elaboration $error.
// CONFIGURATION
//  FIFO_WR_LEVEL_HWM_EN defined: adds ports hwm (out, LVL_W, high-water mark) and hwm_clr (in, 1).
//    hwm <= max(hwm, level_next) each cycle; hwm_clr=1 -> hwm <= level_next; rst_n low -> hwm <= 0.
//    flush does not clear hwm (diagnostic survives flush).
//  Not defined: hwm/hwm_clr ports and logic absent; remaining behaviour identical.
// TESTING (WIDTH=8, DEPTH=6, AF_THRESH=5, AE_THRESH=1 unless stated)
//  1. Reset, push 0x11..0x16 back-to-back, no pop -> level 1..6, almost_empty drops at level 2,
//     almost_full rises at level 5, w_valid=0 at level 6, r_data=0x11.
//  2. Full, push 0x77 with r_ready=0 -> ignored, level 6; then pop 6 -> 0x11..0x16 in order, r_valid=0, level 0.
//  3. 20 cycles simultaneous push/pop at level 3 -> pointers wrap 5->0 repeatedly, level stays 3, output order matches input.
//  4. SKID=1, full, w_ready=r_ready=1 pushing 0xAA -> w_valid=1, 0x11 popped, level 6; after 5 more pops r_data=0xAA.
//  5. Level 4, flush=1 with w_ready=1 -> next cycle level 0, r_valid=0, w_valid=1; rst_n=0 at level 3 -> same result.
//  6. HWM_EN: push 4, pop 4 -> hwm=4, level 0; hwm_clr pulse -> hwm=0; push 2 -> hwm=2; flush -> hwm stays 2.

Source files
------------

// File: rtl/fifo_wr_level_if.sv
// Write/read handshake bundle for fifo_wr_level.
// Latency: none, this is wiring only.
// Backpressure: w_valid/r_valid come from the FIFO; w_ready/r_ready are the push/pop strobes.
//
// Signals
//   w_valid  FIFO -> producer  space available
//   w_ready  producer -> FIFO  push strobe
//   w_data   producer -> FIFO  write word
//   r_valid  FIFO -> consumer  data available
//   r_ready  consumer -> FIFO  pop strobe
//   r_data   FIFO -> consumer  head word
interface fifo_wr_level_if #(
   parameter int WIDTH = 8
);
   logic             w_valid;
   logic             w_ready;
   logic [WIDTH-1:0] w_data;
   logic             r_valid;
   logic             r_ready;
   logic [WIDTH-1:0] r_data;

   // The FIFO itself.
   modport slave (
      output w_valid,
      input  w_ready,
      input  w_data,
      output r_valid,
      input  r_ready,
      output r_data
   );

   // Producer/consumer side.
   modport master (
      input  w_valid,
      output w_ready,
      output w_data,
      input  r_valid,
      output r_ready,
      input  r_data
   );
endinterface

// File: rtl/fifo_wr_level.sv
// Single-clock FIFO with occupancy level, almost-full/almost-empty watermarks and sync flush.
// Latency: a pushed word appears on r_data with r_valid=1 one cycle after the push; no bypass.
// Backpressure: w_valid=0 when full (SKID=1: w_valid follows r_ready when full); r_valid=0 when empty.
//
// Ports
//   clk, rst_n     clock and synchronous active-low reset
//   flush          synchronous clear of pointers and level (memory untouched)
//   bus            fifo_wr_level_if.slave: w_valid/w_ready/w_data, r_valid/r_ready/r_data
//   level          entry count 0..DEPTH
//   almost_full    level >= AF_THRESH
//   almost_empty   level <= AE_THRESH
//   hwm, hwm_clr   high-water mark and its clear, present only with FIFO_WR_LEVEL_HWM_EN defined
module fifo_wr_level #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 6,
   parameter int SKID      = 0,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int AE_THRESH = 1,
   localparam int LVL_W    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
`ifdef FIFO_WR_LEVEL_HWM_EN
   input  logic             hwm_clr,
   output logic [LVL_W-1:0] hwm,
`endif
   fifo_wr_level_if.slave   bus,
   output logic [LVL_W-1:0] level,
   output logic             almost_full,
   output logic             almost_empty
);

   localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   if (DEPTH < 2) begin : g_chk_depth
      $error("fifo_wr_level: DEPTH must be at least 2");
   end
   if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_chk_thresh
      $error("fifo_wr_level: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] w_ptr;
   logic [PTR_W-1:0] r_ptr;
   logic             w_ph;
   logic             r_ph;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [LVL_W-1:0] level_next;

   // Pointers run 0..DEPTH-1 (not a power of two in general), so a
   // phase bit toggling on each wrap tells full from empty.
   assign full  = (w_ptr == r_ptr) && (w_ph != r_ph);
   assign empty = (w_ptr == r_ptr) && (w_ph == r_ph);

   // With SKID the slot freed by a same-cycle pop may be refilled while full.
   assign bus.w_valid = ~full | ((SKID != 0) & bus.r_ready);
   assign bus.r_valid = ~empty;
   assign bus.r_data  = mem[r_ptr];

   assign push = bus.w_valid & bus.w_ready;
   assign pop  = bus.r_valid & bus.r_ready;

   always_comb begin
      level_next = level;
      if (flush) begin
         level_next = '0;
      end else if (push && !pop) begin
         level_next = level + LVL_W'(1);
      end else if (pop && !push) begin
         level_next = level - LVL_W'(1);
      end
   end

   assign almost_full  = (level >= LVL_W'(AF_THRESH));
   assign almost_empty = (level <= LVL_W'(AE_THRESH));

   // Storage has no reset; only pointers define what is valid.
   always_ff @(posedge clk) begin
      if (rst_n && !flush && push) begin
         mem[w_ptr] <= bus.w_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         w_ptr <= '0;
         r_ptr <= '0;
         w_ph  <= 1'b0;
         r_ph  <= 1'b0;
      end else begin
         if (push) begin
            if (w_ptr == PTR_LAST) begin
               w_ptr <= '0;
               w_ph  <= ~w_ph;
            end else begin
               w_ptr <= w_ptr + PTR_W'(1);
            end
         end
         if (pop) begin
            if (r_ptr == PTR_LAST) begin
               r_ptr <= '0;
               r_ph  <= ~r_ph;
            end else begin
               r_ptr <= r_ptr + PTR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         level <= '0;
      end else begin
         level <= level_next;
      end
   end

`ifdef FIFO_WR_LEVEL_HWM_EN
   // Tracks level_next so the mark matches the level visible after this edge.
   // Flush deliberately leaves the mark alone so it survives for diagnosis.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hwm <= '0;
      end else if (hwm_clr) begin
         hwm <= level_next;
      end else if (level_next > hwm) begin
         hwm <= level_next;
      end
   end
`endif

endmodule
